// File: rtl/regfile_sched.sv
// Arbiter and sequencer in front of the single-port 16x16 register file.
// Serialises operand fetches and writebacks and write-protects the constant table.
//
// state | meaning
// IDLE  | arbitrate wb_req / op_req, round-robin on conflict
// WRITE | write slot: wb_ack, rf_rw=1 unless index is protected (then wb_err)
// READ1 | rf_regnum=src1, op_data1 captured at the closing edge
// READ2 | rf_regnum=src2, op_data2 captured at the closing edge
// RESP  | op_valid pulse, captured data stable
module regfile_sched #(
    parameter int NREGS   = 16,
    parameter int WP_BASE = 8,
    localparam int IDX_W  = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_req,
    input  logic             op_two,
    input  logic [IDX_W-1:0] op_src1,
    input  logic [IDX_W-1:0] op_src2,
    output logic             op_valid,
    output logic [15:0]      op_data1,
    output logic [15:0]      op_data2,
    input  logic             wb_req,
    input  logic [IDX_W-1:0] wb_reg,
    input  logic [15:0]      wb_data,
    output logic             wb_ack,
    output logic             wb_err,
    output logic [7:0]       rf_regnum,
    output logic             rf_rw,
    output logic [15:0]      rf_datain,
    input  logic [15:0]      rf_dataout
);

    localparam bit               WP_ON  = (WP_BASE < NREGS);
    localparam logic [IDX_W-1:0] WP_IDX = IDX_W'(WP_BASE);

    typedef enum logic [2:0] {IDLE, WRITE, READ1, READ2, RESP} state_t;
    typedef enum logic {PRIO_WB, PRIO_OP} prio_t;

    state_t           state, state_nxt;
    prio_t            prio, prio_nxt;
    logic             grant_wb, grant_op, wp_hit;
    logic             op_two_q, op_two_nxt;
    logic [IDX_W-1:0] src2_q, src2_nxt;
    logic             op_valid_nxt, wb_ack_nxt, wb_err_nxt, rf_rw_nxt;
    logic [15:0]      op_data1_nxt, op_data2_nxt, rf_datain_nxt;
    logic [7:0]       rf_regnum_nxt;

    assign wp_hit   = WP_ON && (wb_reg >= WP_IDX);
    assign grant_wb = (state == IDLE) && wb_req && (!op_req || prio == PRIO_WB);
    assign grant_op = (state == IDLE) && op_req && !grant_wb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            prio  <= PRIO_WB;
        end else begin
            state <= state_nxt;
            prio  <= prio_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        prio_nxt  = prio;
        case (state)
            IDLE: begin
                if (grant_wb) begin
                    state_nxt = WRITE;
                    prio_nxt  = PRIO_OP;
                end else if (grant_op) begin
                    state_nxt = READ1;
                    prio_nxt  = PRIO_WB;
                end
            end
            WRITE:   state_nxt = IDLE;
            READ1:   state_nxt = op_two_q ? READ2 : RESP;
            READ2:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Every output is the registered copy of the value computed here for the next state.
    always_comb begin
        op_valid_nxt  = 1'b0;
        wb_ack_nxt    = 1'b0;
        wb_err_nxt    = 1'b0;
        rf_rw_nxt     = 1'b0;
        op_data1_nxt  = op_data1;
        op_data2_nxt  = op_data2;
        rf_regnum_nxt = rf_regnum;
        rf_datain_nxt = rf_datain;
        op_two_nxt    = op_two_q;
        src2_nxt      = src2_q;
        case (state)
            IDLE: begin
                if (grant_wb) begin
                    wb_ack_nxt = 1'b1;
                    if (wp_hit) begin
                        wb_err_nxt = 1'b1;
                    end else begin
                        rf_rw_nxt     = 1'b1;
                        rf_regnum_nxt = 8'(wb_reg);
                        rf_datain_nxt = wb_data;
                    end
                end else if (grant_op) begin
                    rf_regnum_nxt = 8'(op_src1);
                    op_two_nxt    = op_two;
                    src2_nxt      = op_src2;
                end
            end
            READ1: begin
                op_data1_nxt = rf_dataout;
                if (op_two_q) begin
                    rf_regnum_nxt = 8'(src2_q);
                end else begin
                    op_data2_nxt = 16'h0000;
                    op_valid_nxt = 1'b1;
                end
            end
            READ2: begin
                op_data2_nxt = rf_dataout;
                op_valid_nxt = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid  <= 1'b0;
            op_data1  <= 16'h0000;
            op_data2  <= 16'h0000;
            wb_ack    <= 1'b0;
            wb_err    <= 1'b0;
            rf_regnum <= 8'h00;
            rf_rw     <= 1'b0;
            rf_datain <= 16'h0000;
            op_two_q  <= 1'b0;
            src2_q    <= '0;
        end else begin
            op_valid  <= op_valid_nxt;
            op_data1  <= op_data1_nxt;
            op_data2  <= op_data2_nxt;
            wb_ack    <= wb_ack_nxt;
            wb_err    <= wb_err_nxt;
            rf_regnum <= rf_regnum_nxt;
            rf_rw     <= rf_rw_nxt;
            rf_datain <= rf_datain_nxt;
            op_two_q  <= op_two_nxt;
            src2_q    <= src2_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_sched.sv
// Directed bench for regfile_sched with a behavioural 16x16 register file attached.
module tb_regfile_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_req, op_two;
    logic [3:0]  op_src1, op_src2;
    logic        op_valid;
    logic [15:0] op_data1, op_data2;
    logic        wb_req;
    logic [3:0]  wb_reg;
    logic [15:0] wb_data;
    logic        wb_ack, wb_err;
    logic [7:0]  rf_regnum;
    logic        rf_rw;
    logic [15:0] rf_datain, rf_dataout;

    logic [15:0] rf_mem [16];
    logic        pl_en;
    logic [3:0]  pl_idx;
    logic [15:0] pl_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    regfile_sched #(.NREGS(16), .WP_BASE(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_req     (op_req),
        .op_two     (op_two),
        .op_src1    (op_src1),
        .op_src2    (op_src2),
        .op_valid   (op_valid),
        .op_data1   (op_data1),
        .op_data2   (op_data2),
        .wb_req     (wb_req),
        .wb_reg     (wb_reg),
        .wb_data    (wb_data),
        .wb_ack     (wb_ack),
        .wb_err     (wb_err),
        .rf_regnum  (rf_regnum),
        .rf_rw      (rf_rw),
        .rf_datain  (rf_datain),
        .rf_dataout (rf_dataout)
    );

    // Register file: combinational read, write on the rising edge when rf_rw=1.
    assign rf_dataout = rf_mem[rf_regnum[3:0]];
    always @(posedge clk) begin
        if (rf_rw)
            rf_mem[rf_regnum[3:0]] <= rf_datain;
        else if (pl_en)
            rf_mem[pl_idx] <= pl_data;
    end

    function automatic logic [15:0] preload_val(input int i);
        case (i)
            1:       return 16'h0011;
            2:       return 16'h0022;
            9:       return 16'h5A5A;
            12:      return 16'hC0DE;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called with the DUT in IDLE at a falling edge; returns in IDLE at a falling edge.
    task automatic do_write(input string tag, input logic [3:0] r, input logic [15:0] d,
                            input logic err);
        wb_req = 1'b1; wb_reg = r; wb_data = d;
        @(negedge clk);
        chk({tag, "_ack"}, wb_ack, 1);
        chk({tag, "_err"}, wb_err, err);
        chk({tag, "_rw"}, rf_rw, !err);
        if (!err) begin
            chk({tag, "_idx"}, rf_regnum, {4'h0, r});
            chk({tag, "_din"}, rf_datain, d);
        end
        wb_req = 1'b0;
        @(negedge clk);
        chk({tag, "_ack_pulse"}, wb_ack, 0);
        chk({tag, "_rw_idle"}, rf_rw, 0);
    endtask

    task automatic do_fetch(input string tag, input logic two, input logic [3:0] s1,
                            input logic [3:0] s2, input logic [15:0] e1, input logic [15:0] e2);
        op_req = 1'b1; op_two = two; op_src1 = s1; op_src2 = s2;
        @(negedge clk);
        chk({tag, "_r1_idx"}, rf_regnum, {4'h0, s1});
        chk({tag, "_r1_valid"}, op_valid, 0);
        if (two) begin
            @(negedge clk);
            chk({tag, "_r2_idx"}, rf_regnum, {4'h0, s2});
            chk({tag, "_r2_valid"}, op_valid, 0);
        end
        @(negedge clk);
        chk({tag, "_valid"}, op_valid, 1);
        chk({tag, "_d1"}, op_data1, e1);
        chk({tag, "_d2"}, op_data2, e2);
        op_req = 1'b0;
        @(negedge clk);
        chk({tag, "_valid_pulse"}, op_valid, 0);
        chk({tag, "_d1_hold"}, op_data1, e1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wb_at [2];
        int op_at [2];
        int wb_n, op_n;

        rst_n = 1'b0;
        op_req = 1'b0; op_two = 1'b0; op_src1 = 4'h0; op_src2 = 4'h0;
        wb_req = 1'b0; wb_reg = 4'h0; wb_data = 16'h0000;
        pl_en = 1'b1; pl_idx = 4'h0; pl_data = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            pl_idx  = 4'(i);
            pl_data = preload_val(i);
            @(negedge clk);
        end
        pl_en = 1'b0;

        chk("rst_op_valid", op_valid, 0);
        chk("rst_op_data1", op_data1, 0);
        chk("rst_op_data2", op_data2, 0);
        chk("rst_wb_ack", wb_ack, 0);
        chk("rst_wb_err", wb_err, 0);
        chk("rst_rf_regnum", rf_regnum, 0);
        chk("rst_rf_rw", rf_rw, 0);
        chk("rst_rf_datain", rf_datain, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_write("wr_r3", 4'd3, 16'hBEEF, 1'b0);
        do_fetch("rd_r3", 1'b0, 4'd3, 4'd0, 16'hBEEF, 16'h0000);
        do_fetch("rd_r1r2", 1'b1, 4'd1, 4'd2, 16'h0011, 16'h0022);

        do_write("wr_wp9", 4'd9, 16'h1234, 1'b1);
        do_fetch("rd_r9", 1'b0, 4'd9, 4'd0, 16'h5A5A, 16'h0000);
        do_fetch("rd_same", 1'b1, 4'd2, 4'd2, 16'h0022, 16'h0022);
        do_fetch("rd_r12r1", 1'b1, 4'd12, 4'd1, 16'hC0DE, 16'h0011);
        do_write("wr_r7", 4'd7, 16'h7777, 1'b0);

        // Writeback raised in READ1 must wait for the fetch to finish.
        op_req = 1'b1; op_two = 1'b1; op_src1 = 4'd1; op_src2 = 4'd2;
        @(negedge clk);
        chk("np_r1_idx", rf_regnum, 8'h01);
        wb_req = 1'b1; wb_reg = 4'd5; wb_data = 16'h0055;
        @(negedge clk);
        chk("np_r2_idx", rf_regnum, 8'h02);
        chk("np_r2_ack", wb_ack, 0);
        chk("np_r2_rw", rf_rw, 0);
        @(negedge clk);
        chk("np_valid", op_valid, 1);
        chk("np_d1", op_data1, 16'h0011);
        chk("np_d2", op_data2, 16'h0022);
        chk("np_resp_ack", wb_ack, 0);
        op_req = 1'b0;
        @(negedge clk);
        chk("np_idle_ack", wb_ack, 0);
        @(negedge clk);
        chk("np_wb_ack", wb_ack, 1);
        chk("np_wb_idx", rf_regnum, 8'h05);
        chk("np_wb_rw", rf_rw, 1);
        wb_req = 1'b0;
        @(negedge clk);
        do_fetch("rd_r5", 1'b0, 4'd5, 4'd0, 16'h0055, 16'h0000);

        // Reset in READ2 abandons the fetch; the held request is served again.
        op_req = 1'b1; op_two = 1'b1; op_src1 = 4'd1; op_src2 = 4'd2;
        @(negedge clk);
        @(negedge clk);
        chk("ar_r2_idx", rf_regnum, 8'h02);
        rst_n = 1'b0;
        #1;
        chk("ar_idx_clr", rf_regnum, 8'h00);
        chk("ar_d1_clr", op_data1, 16'h0000);
        chk("ar_valid_clr", op_valid, 0);
        @(negedge clk);
        chk("ar_no_valid", op_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_re_r1_idx", rf_regnum, 8'h01);
        @(negedge clk);
        chk("ar_re_r2_idx", rf_regnum, 8'h02);
        @(negedge clk);
        chk("ar_re_valid", op_valid, 1);
        chk("ar_re_d1", op_data1, 16'h0011);
        chk("ar_re_d2", op_data2, 16'h0022);
        op_req = 1'b0;
        @(negedge clk);

        // Both requesters held out of reset: WB, OP, WB, OP.
        rst_n = 1'b0;
        wb_req = 1'b1; wb_reg = 4'd4; wb_data = 16'h4444;
        op_req = 1'b1; op_two = 1'b0; op_src1 = 4'd4; op_src2 = 4'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wb_at = '{-1, -1};
        op_at = '{-1, -1};
        wb_n = 0;
        op_n = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (wb_ack && wb_n < 2) begin
                wb_at[wb_n] = c;
                wb_n++;
            end
            if (op_valid && op_n < 2) begin
                if (op_n == 0)
                    chk("arb_op_data", op_data1, 16'h4444);
                op_at[op_n] = c;
                op_n++;
            end
        end
        wb_req = 1'b0;
        op_req = 1'b0;
        chk("arb_wb0_cycle", wb_at[0], 1);
        chk("arb_op0_cycle", op_at[0], 4);
        chk("arb_wb1_cycle", wb_at[1], 6);
        chk("arb_op1_cycle", op_at[1], 9);
        @(negedge clk);
        chk("arb_quiet_ack", wb_ack, 0);
        chk("arb_quiet_valid", op_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
